spi_slave_responder: RTL

- SPI mode-0 responder (slave), the far end of the SPI master set up by the SPI control register: cs_ctrl, all_1s/all_0s fill, n_tx_end and n_rx_end word counts.
- Oversamples SCLK/CS_N/MOSI in the clk domain and deserialises MOSI into bytes. Serialises a transmit byte, or a fill pattern, onto MISO.
- Counts the bytes of each CS frame and reports the count at frame end, together with sticky error flags for the local register block.

---
 rtl/spi_slave_responder_if.sv | 32 +++
 rtl/spi_slave_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder_if.sv
// Bus bundle for the SPI mode-0 responder: SPI pins plus the local TX/RX/status
// handshakes. The slave modport is the responder's view of the bundle.
interface spi_slave_responder_if #(
    parameter int N = 5
);
    logic         sclk;
    logic         cs_n;
    logic         mosi;
    logic         miso;
    logic         miso_oe;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         fill_1s;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         frame_done;
    logic [N+1:0] frame_len;
    logic [2:0]   status;
    logic         clr_status;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid, fill_1s, rx_ready, clr_status,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, frame_done, frame_len, status
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid, fill_1s, rx_ready, clr_status,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, frame_done, frame_len, status
    );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: oversampled pins, byte deserialiser, MISO serialiser with
// one-deep TX holding register, per-frame byte count and sticky error flags.
module spi_slave_responder #(
    parameter int N           = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_slave_responder_if.slave  bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_d1_q, cs_d1_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t       state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   rx_sh_q, rx_sh_d;
    logic [7:0]   tx_sh_q, tx_sh_d;
    logic [7:0]   hold_q, hold_d;
    logic         hold_full_q, hold_full_d;
    logic [7:0]   rx_data_q, rx_data_d;
    logic         rx_valid_q, rx_valid_d;
    logic [N+1:0] frame_cnt_q, frame_cnt_d;
    logic [N+1:0] frame_len_q, frame_len_d;
    logic         frame_done_q, frame_done_d;
    logic [2:0]   status_q, status_d;
    logic         tx_load;

    // The cs_n chain resets low so a chip select held low across reset release
    // never looks like a falling edge; the resulting rise in IDLE is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_d1_q   <= 1'b0;
            cs_d1_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            sclk_d1_q   <= sclk_s;
            cs_d1_q     <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d1_q;
    assign sclk_fall = ~sclk_s & sclk_d1_q;
    assign cs_rise   = cs_s & ~cs_d1_q;
    assign cs_fall   = ~cs_s & cs_d1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            rx_sh_q      <= '0;
            tx_sh_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_cnt_q  <= '0;
            frame_len_q  <= '0;
            frame_done_q <= 1'b0;
            status_q     <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_sh_q      <= rx_sh_d;
            tx_sh_q      <= tx_sh_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_len_q  <= frame_len_d;
            frame_done_q <= frame_done_d;
            status_q     <= status_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_sh_d      = rx_sh_q;
        tx_sh_d      = tx_sh_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_cnt_d  = frame_cnt_q;
        frame_len_d  = frame_len_q;
        frame_done_d = 1'b0;
        tx_load      = 1'b0;
        // Clear first so that any set event below in the same clk wins.
        status_d     = bus.clr_status ? 3'b000 : status_q;

        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = ACTIVE;
                    frame_cnt_d = '0;
                    bit_cnt_d   = '0;
                    tx_load     = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    frame_len_d  = frame_cnt_q;
                    if (bit_cnt_q != 3'd0) begin
                        status_d[2] = 1'b1;
                    end
                    bit_cnt_d = '0;
                    rx_sh_d   = '0;
                end else if (sclk_rise) begin
                    rx_sh_d   = {rx_sh_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (frame_cnt_q != '1) begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                        if (!rx_valid_q || bus.rx_ready) begin
                            rx_data_d  = rx_sh_d;
                            rx_valid_d = 1'b1;
                        end else begin
                            status_d[0] = 1'b1;
                        end
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        tx_load = 1'b1;
                    end else begin
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A load sees the holding register as it was at the start of this clk.
        if (tx_load) begin
            if (hold_full_q) begin
                tx_sh_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_sh_d     = {8{bus.fill_1s}};
                status_d[1] = 1'b1;
            end
        end
        if (bus.tx_valid && !hold_full_q) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end
    end

    assign bus.miso       = tx_sh_q[7];
    assign bus.miso_oe    = (state_q == ACTIVE);
    assign bus.tx_ready   = ~hold_full_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_len  = frame_len_q;
    assign bus.status     = status_q;
endmodule
